// File: rtl/dab_param_pkg.sv
// Shared constants, types and helpers for the DAB modulation-parameter loader.
// Frame layout: A5, t1, t2, phi_lo, phi_hi, fs_lo, fs_mid, fs_hi, deadtime, chk.
package dab_param_pkg;

    localparam logic [7:0] HDR    = 8'hA5;
    localparam int         FS_MIN = 500;
    localparam int         FS_MAX = 250000;

    localparam logic [8:0]  DEF_T1  = 9'd223;
    localparam logic [8:0]  DEF_T2  = 9'd128;
    localparam logic [8:0]  DEF_PHI = 9'h1C0;   // -64
    localparam logic [18:0] DEF_FS  = 19'd100000;
    localparam logic [7:0]  DEF_DT  = 8'd20;

    // Byte count value while each payload byte is received (header not counted).
    localparam logic [3:0] IDX_T1     = 4'd0;
    localparam logic [3:0] IDX_T2     = 4'd1;
    localparam logic [3:0] IDX_PHI_LO = 4'd2;
    localparam logic [3:0] IDX_PHI_HI = 4'd3;
    localparam logic [3:0] IDX_FS_LO  = 4'd4;
    localparam logic [3:0] IDX_FS_MID = 4'd5;
    localparam logic [3:0] IDX_FS_HI  = 4'd6;
    localparam logic [3:0] IDX_DT     = 4'd7;
    localparam logic [3:0] IDX_CHK    = 4'd8;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrChk      = 3'd1,
        ErrFsRange  = 3'd2,
        ErrDeadtime = 3'd3,
        ErrPhi      = 3'd4,
        ErrTimeout  = 3'd5
    } err_code_e;

    typedef struct packed {
        logic [8:0]  t1;
        logic [8:0]  t2;
        logic [8:0]  phi;
        logic [18:0] fs;
        logic [7:0]  dt;
    } dab_params_t;

    localparam dab_params_t DEF_PARAMS = '{
        t1:  DEF_T1,
        t2:  DEF_T2,
        phi: DEF_PHI,
        fs:  DEF_FS,
        dt:  DEF_DT
    };

    // Value checks applied after the checksum, in priority order.
    function automatic err_code_e range_check(input logic [18:0] fs, input logic [7:0] dt,
                                              input logic [8:0] phi);
        int fs_val;
        fs_val = int'($signed(fs));
        if (fs_val < FS_MIN || fs_val > FS_MAX) begin
            return ErrFsRange;
        end
        if (dt == 8'd0) begin
            return ErrDeadtime;
        end
        if (phi == 9'h100) begin
            return ErrPhi;
        end
        return ErrNone;
    endfunction

endpackage

// File: rtl/dab_frame_rx.sv
// Byte-stream framer: finds the header, collects the payload, accumulates the XOR checksum
// and flags inter-byte gaps that run too long. Emits one done or timeout strobe per frame.
module dab_frame_rx
    import dab_param_pkg::*;
#(
    parameter int unsigned TimeoutCyc = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output dab_params_t frame,
    output logic        done,
    output logic        chk_ok,
    output logic        timeout
);

    localparam int unsigned GapW = $clog2(TimeoutCyc + 1);

    typedef enum logic [1:0] {StIdle, StPayload, StCheck} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [GapW-1:0] gap_q;
    logic [7:0]  acc_q;
    dab_params_t frame_q;
    logic        done_q;
    logic        chk_ok_q;
    logic        timeout_q;
    logic        start;

    assign start = rx_valid && (rx_data == HDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gap_q     <= '0;
            acc_q     <= '0;
            frame_q   <= '0;
            done_q    <= 1'b0;
            chk_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                // CHECK is a one-cycle pass-through, so it accepts a header just like IDLE.
                StIdle, StCheck: begin
                    if (start) begin
                        state_q <= StPayload;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        acc_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StPayload: begin
                    if (rx_valid) begin
                        gap_q <= '0;
                        acc_q <= acc_q ^ rx_data;
                        cnt_q <= cnt_q + 4'd1;
                        case (cnt_q)
                            IDX_T1:     frame_q.t1        <= {1'b0, rx_data};
                            IDX_T2:     frame_q.t2        <= {1'b0, rx_data};
                            IDX_PHI_LO: frame_q.phi[7:0]  <= rx_data;
                            IDX_PHI_HI: frame_q.phi[8]    <= rx_data[0];
                            IDX_FS_LO:  frame_q.fs[7:0]   <= rx_data;
                            IDX_FS_MID: frame_q.fs[15:8]  <= rx_data;
                            IDX_FS_HI:  frame_q.fs[18:16] <= rx_data[2:0];
                            IDX_DT:     frame_q.dt        <= rx_data;
                            default: ;
                        endcase
                        if (cnt_q == IDX_CHK) begin
                            state_q  <= StCheck;
                            done_q   <= 1'b1;
                            chk_ok_q <= (acc_q == rx_data);
                        end
                    end else if (gap_q == GapW'(TimeoutCyc - 1)) begin
                        state_q   <= StIdle;
                        timeout_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign frame   = frame_q;
    assign done    = done_q;
    assign chk_ok  = chk_ok_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/dab_param_loader.sv
// Validates DAB parameter frames from the UART into a shadow set and applies the shadow to the
// live outputs on the next rising edge of the period marker, so parameters never change mid-period.
module dab_param_loader
    import dab_param_pkg::*;
#(
    parameter int unsigned TimeoutCyc = 10000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               trigger,
    output logic signed [8:0]  t1,
    output logic signed [8:0]  t2,
    output logic signed [8:0]  phi,
    output logic signed [18:0] fs_DAB,
    output logic [7:0]         deadtime,
    output logic               upd_pending,
    output logic               applied,
    output logic               frame_ok,
    output logic               frame_err,
    output logic [2:0]         err_code
);

    dab_params_t frame;
    logic        frame_done;
    logic        frame_chk_ok;
    logic        frame_timeout;

    dab_frame_rx #(
        .TimeoutCyc(TimeoutCyc)
    ) u_frame_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .frame   (frame),
        .done    (frame_done),
        .chk_ok  (frame_chk_ok),
        .timeout (frame_timeout)
    );

    dab_params_t shadow_q;
    dab_params_t active_q;
    logic        trig_q;
    logic        pending_q;
    logic        applied_q;
    logic        ok_q;
    logic        err_q;
    err_code_e   err_code_q;
    err_code_e   verdict;
    logic        trig_rise;

    assign trig_rise = trigger && !trig_q;

    always_comb begin
        verdict = ErrNone;
        if (!frame_chk_ok) begin
            verdict = ErrChk;
        end else begin
            verdict = range_check(frame.fs, frame.dt, frame.phi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q     <= 1'b0;
            shadow_q   <= DEF_PARAMS;
            active_q   <= DEF_PARAMS;
            pending_q  <= 1'b0;
            applied_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            trig_q    <= trigger;
            applied_q <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            // The edge sees the pre-edge shadow; a frame accepted this cycle re-arms pending.
            if (trig_rise && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
                applied_q <= 1'b1;
            end
            if (frame_done) begin
                if (verdict == ErrNone) begin
                    shadow_q  <= frame;
                    pending_q <= 1'b1;
                    ok_q      <= 1'b1;
                end else begin
                    err_q      <= 1'b1;
                    err_code_q <= verdict;
                end
            end else if (frame_timeout) begin
                err_q      <= 1'b1;
                err_code_q <= ErrTimeout;
            end
        end
    end

    assign t1          = active_q.t1;
    assign t2          = active_q.t2;
    assign phi         = active_q.phi;
    assign fs_DAB      = active_q.fs;
    assign deadtime    = active_q.dt;
    assign upd_pending = pending_q;
    assign applied     = applied_q;
    assign frame_ok    = ok_q;
    assign frame_err   = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_dab_param_loader.sv
// Randomized scoreboard bench for dab_param_loader: stimulus pushes expected frame results and
// applies into queues, a negedge monitor pops and compares whenever the DUT pulses.
module tb_dab_param_loader;

    localparam int TO = 10000;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              trigger;
    logic signed [8:0] t1, t2, phi;
    logic signed [18:0] fs_DAB;
    logic [7:0]        deadtime;
    logic              upd_pending, applied, frame_ok, frame_err;
    logic [2:0]        err_code;
    logic [53:0]       outs;

    dab_param_loader #(
        .TimeoutCyc(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .trigger    (trigger),
        .t1         (t1),
        .t2         (t2),
        .phi        (phi),
        .fs_DAB     (fs_DAB),
        .deadtime   (deadtime),
        .upd_pending(upd_pending),
        .applied    (applied),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    assign outs = {t1, t2, phi, fs_DAB, deadtime};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: parameters as plain integers.
    typedef struct {int t1; int t2; int phi; int fs; int dt;} prm_t;
    typedef struct {bit ok; int err; int min_c; int max_c;} res_t;
    typedef struct {logic [53:0] outs; int at_c;} app_t;

    localparam prm_t DEFP = '{223, 128, -64, 100000, 20};

    res_t res_q[$];
    app_t app_q[$];
    prm_t m_shadow = DEFP;
    prm_t m_active = DEFP;
    bit   m_pending = 0;
    int   m_err = 0;

    function automatic logic [53:0] pack(input prm_t p);
        return {9'(p.t1), 9'(p.t2), 9'(p.phi), 19'(p.fs), 8'(p.dt)};
    endfunction

    function automatic int exp_code(input prm_t p, input bit chk_bad);
        if (chk_bad) return 1;
        if (p.fs < 500 || p.fs > 250000) return 2;
        if (p.dt == 0) return 3;
        if (p.phi == -256) return 4;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input prm_t p, input logic [7:0] flip, input int max_gap,
                              output int chk_cyc);
        logic [7:0]  b[9];
        logic [8:0]  phi9;
        logic [18:0] fs19;
        logic [7:0]  junk;
        phi9 = 9'(p.phi);
        fs19 = 19'(p.fs);
        b[0] = 8'(p.t1);
        b[1] = 8'(p.t2);
        b[2] = phi9[7:0];
        b[3] = {7'($urandom), phi9[8]};
        b[4] = fs19[7:0];
        b[5] = fs19[15:8];
        b[6] = {5'($urandom), fs19[18:16]};
        b[7] = 8'(p.dt);
        b[8] = flip;
        for (int i = 0; i < 8; i++) b[8] ^= b[i];
        repeat ($urandom_range(2, 0)) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h00;
            send_byte(junk, int'($urandom_range(max_gap, 0)));
        end
        send_byte(8'hA5, int'($urandom_range(max_gap, 0)));
        for (int i = 0; i < 8; i++) send_byte(b[i], int'($urandom_range(max_gap, 0)));
        chk_cyc = cyc;
        send_byte(b[8], 0);
    endtask

    task automatic do_frame(input prm_t p, input bit chk_bad, input int max_gap,
                            input bit trig_sync);
        int   c;
        res_t r;
        app_t a;
        logic [7:0] flip;
        flip = chk_bad ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
        send_frame(p, flip, max_gap, c);
        if (trig_sync) begin
            // Rising edge lands in the cycle the frame is judged.
            trigger = 1'b1;
            if (m_pending) begin
                a.outs = pack(m_shadow);
                a.at_c = cyc + 1;
                app_q.push_back(a);
                m_active  = m_shadow;
                m_pending = 0;
            end
        end
        r.ok    = (exp_code(p, chk_bad) == 0);
        r.err   = r.ok ? m_err : exp_code(p, chk_bad);
        r.min_c = c + 2;
        r.max_c = c + 2;
        res_q.push_back(r);
        if (r.ok) begin
            m_shadow  = p;
            m_pending = 1;
        end else begin
            m_err = r.err;
        end
        if (trig_sync) begin
            tick();
            trigger = 1'b0;
        end
    endtask

    task automatic settle(input string tag);
        tick();
        tick();
        check({tag, "_pending"}, upd_pending, m_pending);
        check({tag, "_outputs"}, outs, pack(m_active));
        check({tag, "_err_code"}, err_code, m_err);
    endtask

    task automatic pulse_trigger(input int hold);
        app_t a;
        trigger = 1'b1;
        if (m_pending) begin
            a.outs = pack(m_shadow);
            a.at_c = cyc + 1;
            app_q.push_back(a);
            m_active  = m_shadow;
            m_pending = 0;
        end
        repeat (hold) tick();
        trigger = 1'b0;
        settle("trigger");
    endtask

    function automatic prm_t rand_prm();
        prm_t p;
        int   sel;
        p.t1 = int'($urandom_range(255, 0));
        p.t2 = int'($urandom_range(255, 0));
        p.phi = ($urandom_range(9, 0) == 0) ? -256 : int'($urandom_range(510, 0)) - 255;
        p.dt = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 1));
        sel = int'($urandom_range(9, 0));
        case (sel)
            0: p.fs = 499;
            1: p.fs = 250001;
            2: p.fs = 500;
            3: p.fs = 250000;
            4: begin
                p.fs = int'($urandom_range(524287, 0));
                if (p.fs >= 262144) p.fs -= 524288;
            end
            default: p.fs = int'($urandom_range(250000, 500));
        endcase
        return p;
    endfunction

    // Monitor: every result or apply pulse must match the head of its queue.
    always @(negedge clk) begin
        res_t r;
        app_t a;
        if (!rst) begin
            if (frame_ok || frame_err) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", {frame_ok, frame_err}, 2'b00);
                end else begin
                    r = res_q.pop_front();
                    check("result_ok", frame_ok, r.ok);
                    check("result_err", frame_err, !r.ok);
                    check("result_err_code", err_code, r.err);
                    check("result_cycle_in_window", (cyc >= r.min_c) && (cyc <= r.max_c), 1);
                end
            end
            if (applied) begin
                if (app_q.size() == 0) begin
                    check("unexpected_apply", applied, 0);
                end else begin
                    a = app_q.pop_front();
                    check("apply_outputs", outs, a.outs);
                    check("apply_cycle", cyc, a.at_c);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   c;
        res_t r;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        trigger = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("reset_outputs", outs, pack(DEFP));
        check("reset_flags", {upd_pending, applied, frame_ok, frame_err}, 4'b0000);
        check("reset_err_code", err_code, 0);

        // Nominal frame, held until the period marker.
        do_frame('{200, 100, -32, 50000, 10}, 0, 1, 0);
        settle("nominal");
        pulse_trigger(1);

        do_frame('{200, 100, -32, 50000, 10}, 1, 1, 0);
        settle("bad_chk");
        do_frame('{10, 20, 30, 499, 0}, 0, 0, 0);
        settle("fs_low_dt0");
        do_frame('{10, 20, 30, 250001, 5}, 0, 0, 0);
        settle("fs_high");
        do_frame('{10, 20, 30, 1000, 0}, 0, 0, 0);
        settle("dt0");
        do_frame('{10, 20, -256, 1000, 7}, 0, 0, 0);
        settle("phi_min");
        do_frame('{10, 20, -256, 1, 0}, 1, 0, 0);
        settle("chk_priority");
        do_frame('{0, 255, 255, 500, 255}, 0, 2, 0);
        do_frame('{255, 0, -255, 250000, 1}, 0, 2, 0);
        settle("last_wins");
        pulse_trigger(2);

        for (int i = 0; i < 40; i++) begin
            do_frame(rand_prm(), $urandom_range(5, 0) == 0, 3, 0);
            settle("random");
            if ($urandom_range(1, 0) == 1) pulse_trigger(int'($urandom_range(3, 1)));
        end

        // Inter-byte gap timeout, then recovery.
        send_byte(8'hA5, 0);
        send_byte(8'h12, 1);
        send_byte(8'h34, 0);
        c = cyc;
        send_byte(8'h56, 0);
        r.ok = 0;
        r.err = 5;
        r.min_c = c + TO;
        r.max_c = c + TO + 3;
        res_q.push_back(r);
        m_err = 5;
        repeat (TO + 8) tick();
        check("timeout_reported", res_q.size(), 0);
        settle("timeout");
        do_frame('{1, 2, 3, 4000, 9}, 0, 1, 0);
        settle("after_timeout");
        pulse_trigger(1);

        // Acceptance coincides with a trigger edge, nothing pending before.
        do_frame('{77, 88, -99, 123456, 42}, 0, 1, 1);
        settle("sync_nopend");
        pulse_trigger(1);
        // Same, with an older frame pending: the older one applies, the new one waits.
        do_frame('{11, 22, 33, 60000, 3}, 0, 1, 0);
        do_frame('{44, 55, -66, 70000, 4}, 0, 1, 1);
        settle("sync_pend");
        pulse_trigger(1);

        // Reset in the middle of a frame.
        send_byte(8'hA5, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_shadow = DEFP;
        m_active = DEFP;
        m_pending = 0;
        m_err = 0;
        check("midreset_flags", {upd_pending, applied, frame_ok, frame_err}, 4'b0000);
        settle("midreset");
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_frame('{150, 60, 100, 20000, 15}, 0, 1, 0);
        settle("post_reset");
        pulse_trigger(1);

        for (int i = 0; i < 20 && (res_q.size() != 0 || app_q.size() != 0); i++) tick();
        check("results_drained", res_q.size(), 0);
        check("applies_drained", app_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
